// File: rtl/ptp_pkg.sv
// Shared constants and adjust FSM encoding for the PTP timestamp source.
// Increments are 4.16 fixed-point ns; ns_mod counts ns within the current second.
package ptp_pkg;

   localparam int unsigned NS_PER_SEC = 32'd1_000_000_000;
   localparam int          INC_NS_W   = 4;
   localparam int          INC_FNS_W  = 16;
   localparam int          INC_W      = INC_NS_W + INC_FNS_W;
   localparam int          NS_MOD_W   = 30;

   typedef enum logic {
      ADJ_IDLE   = 1'b0,
      ADJ_ACTIVE = 1'b1
   } adj_state_t;

endpackage

// File: rtl/ptp_adj_ctrl.sv
// Adjust controller: accepts an offset request and holds it active for
// adj_count cycles using a down-counter with a terminal-count compare.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ADJ_IDLE   | no adjust in progress, adj_ready high
//   ADJ_ACTIVE | adj_delta applied each cycle, counter runs down to zero
module ptp_adj_ctrl
   import ptp_pkg::*;
#(
   parameter int DELTA_W = INC_W,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               adj_valid,
   input  logic [CNT_W-1:0]   adj_count,
   input  logic [DELTA_W-1:0] adj_delta_in,
   input  logic               abort,
   output logic               adj_ready,
   output logic               adj_active,
   output logic [DELTA_W-1:0] adj_delta
);

   adj_state_t       state;
   adj_state_t       state_next;
   logic [CNT_W-1:0] cnt;
   logic             accept;

   // A zero-length request, or one colliding with a set, is dropped.
   assign accept = adj_valid && (state == ADJ_IDLE) && (adj_count != '0) && !abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ADJ_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         adj_delta <= '0;
      end else if (accept) begin
         cnt       <= adj_count - CNT_W'(1);
         adj_delta <= adj_delta_in;
      end else if ((state == ADJ_ACTIVE) && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ADJ_IDLE:   if (accept) state_next = ADJ_ACTIVE;
         ADJ_ACTIVE: if (abort || (cnt == '0)) state_next = ADJ_IDLE;
         default:    state_next = ADJ_IDLE;
      endcase
   end

   always_comb begin
      adj_ready  = (state == ADJ_IDLE);
      adj_active = (state == ADJ_ACTIVE);
   end

endmodule

// File: rtl/ptp_ts_source.sv
// 64-bit PTP timestamp generator (48-bit ns . 16-bit fractional ns) with
// period update, step load, bounded frequency adjust and pulse-per-second.
module ptp_ts_source
   import ptp_pkg::*;
#(
   parameter int                    TS_WIDTH   = 64,
   parameter int                    NS_WIDTH   = INC_NS_W,
   parameter int                    FNS_WIDTH  = INC_FNS_W,
   parameter logic [NS_WIDTH-1:0]   PERIOD_NS  = 4'h6,
   parameter logic [FNS_WIDTH-1:0]  PERIOD_FNS = 16'h6666
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NS_WIDTH-1:0]           input_period_ns,
   input  logic [FNS_WIDTH-1:0]          input_period_fns,
   input  logic                          input_period_valid,
   input  logic [TS_WIDTH-1:0]           input_ts_set,
   input  logic [NS_MOD_W-1:0]           input_ts_set_ns_mod,
   input  logic                          input_ts_set_valid,
   input  logic [NS_WIDTH+FNS_WIDTH-1:0] input_adj_delta,
   input  logic [15:0]                   input_adj_count,
   input  logic                          input_adj_valid,
   output logic                          input_adj_ready,
   output logic [TS_WIDTH-1:0]           output_ts,
   output logic                          output_ts_step,
   output logic                          output_pps
);

   localparam int IW    = NS_WIDTH + FNS_WIDTH;
   localparam int SUM_W = NS_MOD_W + 1;

   logic [NS_WIDTH-1:0]  period_ns;
   logic [FNS_WIDTH-1:0] period_fns;
   logic                 adj_active;
   logic [IW-1:0]        adj_delta;
   logic [IW+1:0]        inc_sum;
   logic [IW:0]          inc_eff;
   logic [TS_WIDTH-1:0]  ts_next;
   logic                 fns_carry;
   logic [SUM_W-1:0]     ns_mod_sum;
   logic [NS_MOD_W-1:0]  ns_mod_wrapped;
   logic [NS_MOD_W-1:0]  ns_mod_next;
   logic [NS_MOD_W-1:0]  ns_mod;
   logic                 sec_wrap;

   ptp_adj_ctrl #(
      .DELTA_W (IW),
      .CNT_W   (16)
   ) u_adj_ctrl (
      .clk          (clk),
      .rst_n        (rst_n),
      .adj_valid    (input_adj_valid),
      .adj_count    (input_adj_count),
      .adj_delta_in (input_adj_delta),
      .abort        (input_ts_set_valid),
      .adj_ready    (input_adj_ready),
      .adj_active   (adj_active),
      .adj_delta    (adj_delta)
   );

   // Two guard bits hold the signed sum; a negative result clamps to zero.
   always_comb begin
      inc_sum = {2'b00, period_ns, period_fns}
              + (adj_active ? {{2{adj_delta[IW-1]}}, adj_delta} : '0);
      inc_eff = inc_sum[IW+1] ? '0 : inc_sum[IW:0];
   end

   // Carry out of the fractional field recovered from the full-width sum.
   always_comb begin
      ts_next        = output_ts + TS_WIDTH'(inc_eff);
      fns_carry      = ts_next[FNS_WIDTH] ^ output_ts[FNS_WIDTH] ^ inc_eff[FNS_WIDTH];
      ns_mod_sum     = {1'b0, ns_mod} + SUM_W'(inc_eff[IW:FNS_WIDTH]) + SUM_W'(fns_carry);
      sec_wrap       = (ns_mod_sum >= SUM_W'(NS_PER_SEC));
      ns_mod_wrapped = NS_MOD_W'(ns_mod_sum - SUM_W'(NS_PER_SEC));
      ns_mod_next    = sec_wrap ? ns_mod_wrapped : ns_mod_sum[NS_MOD_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_ns  <= PERIOD_NS;
         period_fns <= PERIOD_FNS;
      end else if (input_period_valid) begin
         period_ns  <= input_period_ns;
         period_fns <= input_period_fns;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         output_ts      <= '0;
         ns_mod         <= '0;
         output_ts_step <= 1'b0;
         output_pps     <= 1'b0;
      end else if (input_ts_set_valid) begin
         output_ts      <= input_ts_set;
         ns_mod         <= input_ts_set_ns_mod;
         output_ts_step <= 1'b1;
         output_pps     <= 1'b0;
      end else begin
         output_ts      <= ts_next;
         ns_mod         <= ns_mod_next;
         output_ts_step <= 1'b0;
         output_pps     <= sec_wrap;
      end
   end

endmodule

// File: tb/tb_ptp_ts_source.sv
// Scoreboard bench for ptp_ts_source: a behavioural model queues the expected
// outputs of every clock edge and a monitor compares them after the edge.
module tb_ptp_ts_source;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  input_period_ns = '0;
   logic [15:0] input_period_fns = '0;
   logic        input_period_valid = 1'b0;
   logic [63:0] input_ts_set = '0;
   logic [29:0] input_ts_set_ns_mod = '0;
   logic        input_ts_set_valid = 1'b0;
   logic [19:0] input_adj_delta = '0;
   logic [15:0] input_adj_count = '0;
   logic        input_adj_valid = 1'b0;
   logic        input_adj_ready;
   logic [63:0] output_ts;
   logic        output_ts_step;
   logic        output_pps;

   ptp_ts_source dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .input_period_ns     (input_period_ns),
      .input_period_fns    (input_period_fns),
      .input_period_valid  (input_period_valid),
      .input_ts_set        (input_ts_set),
      .input_ts_set_ns_mod (input_ts_set_ns_mod),
      .input_ts_set_valid  (input_ts_set_valid),
      .input_adj_delta     (input_adj_delta),
      .input_adj_count     (input_adj_count),
      .input_adj_valid     (input_adj_valid),
      .input_adj_ready     (input_adj_ready),
      .output_ts           (output_ts),
      .output_ts_step      (output_ts_step),
      .output_pps          (output_pps)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] ts;
      logic        step;
      logic        pps;
      logic        ready;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;

   // Reference model state: time in 1/65536 ns units, ns within the second,
   // remaining adjust cycles and the offset they carry.
   logic [63:0] m_ts;
   longint      m_ns_mod;
   longint      m_period;
   int          m_adj_left;
   longint      m_adj_delta;
   bit          m_ready;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (rst_n && exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("sb_ts", output_ts, mon_e.ts);
         check("sb_step", output_ts_step, mon_e.step);
         check("sb_pps", output_pps, mon_e.pps);
         check("sb_ready", input_adj_ready, mon_e.ready);
      end
   end

   task automatic model_reset();
      m_ts        = '0;
      m_ns_mod    = 0;
      m_period    = 64'h6_6666;
      m_adj_left  = 0;
      m_adj_delta = 0;
      m_ready     = 1'b1;
   endtask

   // Predict the outputs after the coming rising edge from the driven inputs.
   task automatic model_step();
      longint      inc;
      logic [63:0] nts;
      logic [47:0] adv;
      bit          pps;
      bit          step;
      bit          rdy0;
      rdy0 = m_ready;
      inc  = m_period + ((m_adj_left > 0) ? m_adj_delta : 0);
      if (inc < 0) inc = 0;
      step = 1'b0;
      pps  = 1'b0;
      if (input_ts_set_valid) begin
         m_ts       = input_ts_set;
         m_ns_mod   = longint'(input_ts_set_ns_mod);
         step       = 1'b1;
         m_adj_left = 0;
      end else begin
         nts      = m_ts + 64'(inc);
         adv      = nts[63:16] - m_ts[63:16];
         m_ns_mod = m_ns_mod + longint'(adv);
         if (m_ns_mod >= 1000000000) begin
            m_ns_mod = m_ns_mod - 1000000000;
            pps      = 1'b1;
         end
         m_ts = nts;
         if (m_adj_left > 0) m_adj_left--;
      end
      if (input_period_valid) m_period = longint'({input_period_ns, input_period_fns});
      if (!input_ts_set_valid && input_adj_valid && rdy0 && input_adj_count != 0) begin
         m_adj_left  = int'(input_adj_count);
         m_adj_delta = longint'($signed(input_adj_delta));
      end
      m_ready = (m_adj_left == 0);
      exp_q.push_back('{m_ts, step, pps, m_ready});
   endtask

   task automatic clear_inputs();
      input_period_valid  = 1'b0;
      input_period_ns     = '0;
      input_period_fns    = '0;
      input_ts_set_valid  = 1'b0;
      input_ts_set        = '0;
      input_ts_set_ns_mod = '0;
      input_adj_valid     = 1'b0;
      input_adj_delta     = '0;
      input_adj_count     = '0;
   endtask

   task automatic step_cycle();
      model_step();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         clear_inputs();
         step_cycle();
      end
   endtask

   task automatic apply_reset();
      clear_inputs();
      #2 rst_n = 1'b0;
      #1;
      check("rst_ts", output_ts, 64'd0);
      check("rst_step", output_ts_step, 1'b0);
      check("rst_pps", output_pps, 1'b0);
      check("rst_ready", input_adj_ready, 1'b1);
      exp_q.delete();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [63:0] base;
   int          low_cnt;

   initial begin
      model_reset();
      @(negedge clk);
      apply_reset();

      // Ten default increments from zero.
      idle(10);
      check("boot_ts", output_ts, 64'h3F_FFFC);
      check("boot_step", output_ts_step, 1'b0);
      check("boot_pps", output_pps, 1'b0);

      // Step load just below a second boundary.
      clear_inputs();
      input_ts_set        = 64'h0000_0100_0000_0000;
      input_ts_set_ns_mod = 30'd999_999_990;
      input_ts_set_valid  = 1'b1;
      step_cycle();
      check("set_ts", output_ts, 64'h0000_0100_0000_0000);
      check("set_step", output_ts_step, 1'b1);
      check("set_pps", output_pps, 1'b0);
      idle(1);
      check("pps_first_inc", output_pps, 1'b0);
      idle(1);
      check("pps_second_inc", output_pps, 1'b1);
      check("pps_ts", output_ts, 64'h0000_0100_000C_CCCC);
      idle(1);
      check("pps_one_cycle", output_pps, 1'b0);

      // +1 ns for 4 cycles.
      base = m_ts;
      clear_inputs();
      input_adj_valid = 1'b1;
      input_adj_delta = 20'h1_0000;
      input_adj_count = 16'd4;
      step_cycle();
      clear_inputs();
      low_cnt = input_adj_ready ? 0 : 1;
      for (int i = 0; i < 6; i++) begin
         idle(1);
         if (!input_adj_ready) low_cnt++;
      end
      check("adj_pos_ready_low", 64'(low_cnt), 64'd4);
      check("adj_pos_ts", output_ts, base + 64'd7 * 64'h6_6666 + 64'h4_0000);

      // -8 ns for 3 cycles clamps the increment to zero.
      base = m_ts;
      clear_inputs();
      input_adj_valid = 1'b1;
      input_adj_delta = 20'h8_0000;
      input_adj_count = 16'd3;
      step_cycle();
      for (int i = 0; i < 3; i++) begin
         idle(1);
         check("adj_neg_hold", output_ts, base + 64'h6_6666);
      end
      idle(1);
      check("adj_neg_resume", output_ts, base + 64'h6_6666 * 64'd2);

      // Set during an active adjust aborts it.
      clear_inputs();
      input_adj_valid = 1'b1;
      input_adj_delta = 20'h1_0000;
      input_adj_count = 16'd10;
      step_cycle();
      idle(1);
      clear_inputs();
      input_ts_set        = 64'h1234_5678_9ABC_0000;
      input_ts_set_ns_mod = 30'd100;
      input_ts_set_valid  = 1'b1;
      step_cycle();
      check("abort_step", output_ts_step, 1'b1);
      check("abort_ready", input_adj_ready, 1'b1);
      idle(1);
      check("abort_inc", output_ts, 64'h1234_5678_9ABC_0000 + 64'h6_6666);

      // Set, period update and adjust together: adjust dropped, new period from N+2.
      clear_inputs();
      input_ts_set        = 64'h0000_0AAA_0000_8000;
      input_ts_set_ns_mod = 30'd5;
      input_ts_set_valid  = 1'b1;
      input_period_valid  = 1'b1;
      input_period_ns     = 4'd2;
      input_period_fns    = 16'h0000;
      input_adj_valid     = 1'b1;
      input_adj_delta     = 20'h1_0000;
      input_adj_count     = 16'd5;
      step_cycle();
      check("combo_ts", output_ts, 64'h0000_0AAA_0000_8000);
      check("combo_ready", input_adj_ready, 1'b1);
      idle(2);
      check("combo_inc", output_ts, 64'h0000_0AAA_0004_8000);

      // Period change lands on the increment after acceptance.
      base = m_ts;
      clear_inputs();
      input_period_valid = 1'b1;
      input_period_ns    = 4'd3;
      input_period_fns   = 16'h8000;
      step_cycle();
      check("period_old", output_ts, base + 64'h2_0000);
      idle(1);
      check("period_new", output_ts, base + 64'h2_0000 + 64'h3_8000);

      // Zero-count adjust leaves ready high.
      clear_inputs();
      input_adj_valid = 1'b1;
      input_adj_count = 16'd0;
      input_adj_delta = 20'h7_0000;
      step_cycle();
      check("adj_zero_ready", input_adj_ready, 1'b1);

      // Reset in the middle of an adjust.
      clear_inputs();
      input_adj_valid = 1'b1;
      input_adj_delta = 20'h2_0000;
      input_adj_count = 16'd10;
      step_cycle();
      idle(3);
      apply_reset();
      idle(10);
      check("post_rst_ts", output_ts, 64'h3F_FFFC);
      check("post_rst_ready", input_adj_ready, 1'b1);

      // Randomised traffic against the model.
      for (int i = 0; i < 500; i++) begin
         clear_inputs();
         if ($urandom_range(0, 19) == 0) begin
            input_period_valid = 1'b1;
            input_period_ns    = 4'($urandom_range(0, 15));
            input_period_fns   = 16'($urandom);
         end
         if ($urandom_range(0, 29) == 0) begin
            input_ts_set_valid = 1'b1;
            input_ts_set       = {32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 1) == 0)
               input_ts_set_ns_mod = 30'(999_999_900 + $urandom_range(0, 99));
            else
               input_ts_set_ns_mod = 30'($urandom_range(0, 999_999_999));
         end
         if ($urandom_range(0, 7) == 0) begin
            input_adj_valid = 1'b1;
            input_adj_delta = 20'($urandom);
            input_adj_count = 16'($urandom_range(0, 12));
         end
         step_cycle();
      end
      clear_inputs();
      @(posedge clk);
      #2;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
